vin_adc_avg: RTL and testbench
==============================

# vin_adc_avg

Per-channel boxcar averager that sits directly downstream of the MAX10 ADC sequencer block. Consumes its eight free-running 16-bit result registers (adc0..adc7) and produces eight decimated averages of 2^SHIFT samples each. It also emits a one-cycle valid strobe so the register-exchange layer can latch a coherent set of values. A single time-multiplexed adder serves all channels.

## Interface
- DIVIDER, default 1000: sample tick period in clk cycles; legal range DIVIDER >= 10.
- SHIFT, default 4: log2 of samples per average; legal range 0..8.
- clk  input  1  system clock; the same clock that drives the upstream adc0..adc7 registers.
- rst  input  1  synchronous, active-high reset.
- adc0..adc7  input  16 each  raw channel values from the ADC stage, zero-extended 12-bit codes.
- avg0..avg7  output  16 each  registered averages; reset value 0.
- valid  output  1  one-cycle pulse when avg0..avg7 update; reset value 0.

## Operation
- Divider counter `div_cnt`, width clog2(DIVIDER):
  - Counts 0..DIVIDER-1 and wraps to 0.
  - `tick` is asserted in the cycle where div_cnt == DIVIDER-1.
- Accumulators acc0..acc7 are 16+SHIFT bits wide, unsigned. They cannot overflow: 2^SHIFT × 0xFFFF fits.
- Sample counter `smp_cnt` is SHIFT bits wide (treated as 1 bit when SHIFT=0).
- FSM states: IDLE, ACCUM, DUMP.
  - **IDLE**: on tick, go to ACCUM with ch <= 0. Otherwise stay.
  - **ACCUM**: each cycle, acc[ch] <= acc[ch] + adc[ch]; ch increments.
    - adc[ch] is sampled only in its own slot.
    - On the ch == 7 edge: if smp_cnt == 2^SHIFT-1, go to DUMP. Otherwise smp_cnt++ and go to IDLE.
  - **DUMP**: one cycle, all channels in parallel:
    - avgN <= accN >> SHIFT (truncating, low 16 bits).
    - accN <= 0, smp_cnt <= 0, valid <= 1.
    - Go to IDLE.
- valid is 0 in every cycle other than the one following the DUMP edge.
- A tick arriving while the FSM is not IDLE is dropped, not queued. With DIVIDER >= 10 this cannot happen, and it must not corrupt state.
- avg0..avg7 hold their value between DUMPs; they never show partial sums.
- rst, in any state and on a clock edge:
  - Forces IDLE, ch = 0, div_cnt = 0, smp_cnt = 0, acc = 0, avg = 0, valid = 0.
  - A partial accumulation is discarded.
- SHIFT = 0 degenerates to a decimating sample-and-hold: DUMP after every scan, avgN = adcN.

## Timing
- After rst deasserts, the first tick is the 10th cycle when DIVIDER = 10 (div_cnt == 9). In general, ticks recur every DIVIDER cycles.
- Tick edge at T:
  - ACCUM slots ch0..ch7 on edges T+1..T+8. Channel N's input is sampled at edge T+1+N.
  - On a final scan, DUMP is on edge T+9.
  - avg and valid become visible after edge T+9; valid stays high for exactly one cycle.
- Output update period = DIVIDER × 2^SHIFT cycles.
- Throughput: one scan of all 8 channels per tick. There is no back-pressure and no input handshake; the upstream registers are treated as always valid.

## Test plan
- DIVIDER=10, SHIFT=2, adcN held at 100·N+1 → first valid pulse 40 cycles after the first tick slot. Required avgN = 1, 101, …, 701, and valid high exactly 1 cycle.
- Same config, adc0 toggling 0/4095 on alternate ticks, others constant → avg0 = 2047 (8190>>2, truncated); subsequent valid pulses exactly 40 cycles apart.
- SHIFT=4, all inputs 16'hFFFF → avgN = 16'hFFFF with no wrap, which checks the 20-bit accumulator.
- Assert rst for 1 cycle during the ACCUM slot of the 3rd sample → all avg and valid are 0 at once. The next valid arrives 4 full ticks after reset release, and its average excludes all pre-reset samples.
- Change adc3 from 10 to 1000 in the cycle right after its slot but before ch7 → that scan accumulates 10 for channel 3; the next scan accumulates 1000.
- SHIFT=0, DIVIDER=12 → valid pulses every 12 cycles, and avgN equals the adcN value sampled at edge T+1+N of that tick.

Source files
------------

// File: rtl/vin_adc_avg.sv
// Eight-channel boxcar averager for the ADC sequencer results.
// One shared adder walks the channels in consecutive slots after each sample tick.
module vin_adc_avg #(
    parameter int unsigned DIVIDER = 1000,
    parameter int unsigned SHIFT   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] adc0,
    input  logic [15:0] adc1,
    input  logic [15:0] adc2,
    input  logic [15:0] adc3,
    input  logic [15:0] adc4,
    input  logic [15:0] adc5,
    input  logic [15:0] adc6,
    input  logic [15:0] adc7,
    output logic [15:0] avg0,
    output logic [15:0] avg1,
    output logic [15:0] avg2,
    output logic [15:0] avg3,
    output logic [15:0] avg4,
    output logic [15:0] avg5,
    output logic [15:0] avg6,
    output logic [15:0] avg7,
    output logic        valid
);

    localparam int unsigned DW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int unsigned AW = 16 + SHIFT;
    localparam int unsigned SW = (SHIFT == 0) ? 1 : SHIFT;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIVIDER - 1);
    localparam logic [SW-1:0] SMP_LAST = SW'((1 << SHIFT) - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DUMP} state_t;

    state_t          state;
    state_t          state_next;
    logic [DW-1:0]   div_cnt;
    logic            tick;
    logic [2:0]      ch;
    logic [SW-1:0]   smp_cnt;
    logic [AW-1:0]   acc [8];
    logic [15:0]     avg_q [8];
    logic [15:0]     adc_sel;
    logic [AW-1:0]   sum;
    logic            acc_en;
    logic            smp_inc;
    logic            dump;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst)       div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and datapath controls; ticks outside IDLE are ignored.
    always_comb begin
        state_next = state;
        acc_en     = 1'b0;
        smp_inc    = 1'b0;
        dump       = 1'b0;
        case (state)
            IDLE: begin
                if (tick) state_next = ACCUM;
            end
            ACCUM: begin
                acc_en = 1'b1;
                if (ch == 3'd7) begin
                    if (smp_cnt == SMP_LAST) begin
                        state_next = DUMP;
                    end else begin
                        smp_inc    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            DUMP: begin
                dump       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        adc_sel = adc0;
        case (ch)
            3'd0: adc_sel = adc0;
            3'd1: adc_sel = adc1;
            3'd2: adc_sel = adc2;
            3'd3: adc_sel = adc3;
            3'd4: adc_sel = adc4;
            3'd5: adc_sel = adc5;
            3'd6: adc_sel = adc6;
            3'd7: adc_sel = adc7;
            default: adc_sel = adc0;
        endcase
    end

    assign sum = acc[ch] + AW'(adc_sel);

    // Channel slot counter wraps 7 -> 0, so it is back at 0 whenever IDLE is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch      <= '0;
            smp_cnt <= '0;
            valid   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                acc[i]   <= '0;
                avg_q[i] <= '0;
            end
        end else begin
            valid <= dump;
            if (state == IDLE && tick) ch <= '0;
            if (acc_en) begin
                acc[ch] <= sum;
                ch      <= ch + 3'd1;
            end
            if (smp_inc) smp_cnt <= smp_cnt + SW'(1);
            if (dump) begin
                smp_cnt <= '0;
                for (int i = 0; i < 8; i++) begin
                    avg_q[i] <= 16'(acc[i] >> SHIFT);
                    acc[i]   <= '0;
                end
            end
        end
    end

    assign avg0 = avg_q[0];
    assign avg1 = avg_q[1];
    assign avg2 = avg_q[2];
    assign avg3 = avg_q[3];
    assign avg4 = avg_q[4];
    assign avg5 = avg_q[5];
    assign avg6 = avg_q[6];
    assign avg7 = avg_q[7];

endmodule

// File: tb/tb_vin_adc_avg.sv
// Bench for vin_adc_avg: three configurations checked against a timing-rule reference model.
module tb_vin_adc_avg;

    localparam int unsigned DV [3] = '{10, 10, 12};
    localparam int unsigned SV [3] = '{2, 4, 0};

    logic        clk;
    logic        rst;
    logic [15:0] adc_in  [3][8];
    logic [15:0] avg_out [3][8];
    logic        valid_out [3];

    int total;
    int bad;

    // Reference model state: edges since reset, per-channel sums, completed scans.
    int          m_e     [3];
    int          m_sum   [3][8];
    int          m_scans [3];
    logic        m_valid [3];
    logic [15:0] m_avg   [3][8];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        vin_adc_avg #(.DIVIDER(DV[g]), .SHIFT(SV[g])) dut (
            .clk   (clk),
            .rst   (rst),
            .adc0  (adc_in[g][0]),
            .adc1  (adc_in[g][1]),
            .adc2  (adc_in[g][2]),
            .adc3  (adc_in[g][3]),
            .adc4  (adc_in[g][4]),
            .adc5  (adc_in[g][5]),
            .adc6  (adc_in[g][6]),
            .adc7  (adc_in[g][7]),
            .avg0  (avg_out[g][0]),
            .avg1  (avg_out[g][1]),
            .avg2  (avg_out[g][2]),
            .avg3  (avg_out[g][3]),
            .avg4  (avg_out[g][4]),
            .avg5  (avg_out[g][5]),
            .avg6  (avg_out[g][6]),
            .avg7  (avg_out[g][7]),
            .valid (valid_out[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Tick k lands on edge D*k after reset; channel N is sampled D*k+1+N; the
    // 2^S-th scan is dumped at D*k+9.
    always @(posedge clk) begin
        int e, r, d, s;
        for (int i = 0; i < 3; i++) begin
            d = int'(DV[i]);
            s = int'(SV[i]);
            if (rst) begin
                m_e[i]     <= 0;
                m_scans[i] <= 0;
                m_valid[i] <= 1'b0;
                for (int n = 0; n < 8; n++) begin
                    m_sum[i][n] <= 0;
                    m_avg[i][n] <= 16'h0;
                end
            end else begin
                e = m_e[i] + 1;
                r = e % d;
                m_e[i]     <= e;
                m_valid[i] <= 1'b0;
                if (r >= 1 && r <= 8 && e > d)
                    m_sum[i][r-1] <= m_sum[i][r-1] + int'(adc_in[i][r-1]);
                if (r == 8 && e > d)
                    m_scans[i] <= m_scans[i] + 1;
                if (r == 9 && e > d && m_scans[i] == (1 << s)) begin
                    m_valid[i] <= 1'b1;
                    m_scans[i] <= 0;
                    for (int n = 0; n < 8; n++) begin
                        m_avg[i][n] <= 16'(m_sum[i][n] >> s);
                        m_sum[i][n] <= 0;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++)
            for (int n = 0; n < 8; n++)
                adc_in[i][n] = 16'(n * 37 + 5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (valid_out[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_valid inst=%0d got=%b exp=0", i, valid_out[i]);
            end
            for (int n = 0; n < 8; n++) begin
                total++;
                if (avg_out[i][n] !== 16'h0) begin
                    bad++;
                    $display("FAIL reset_avg inst=%0d ch=%0d got=%0d exp=0", i, n, avg_out[i][n]);
                end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_constant();
        int first_v;
        first_v = -1;
        for (int n = 0; n < 8; n++) adc_in[0][n] = 16'(100 * n + 1);
        do_reset();
        for (int e = 1; e <= 60; e++) begin
            @(negedge clk);
            total++;
            if (valid_out[0] !== m_valid[0]) begin
                bad++;
                $display("FAIL const_valid e=%0d got=%b exp=%b", e, valid_out[0], m_valid[0]);
            end
            if (valid_out[0] === 1'b1 && first_v < 0) first_v = e;
            if (e == 49) begin
                for (int n = 0; n < 8; n++) begin
                    total++;
                    if (avg_out[0][n] !== 16'(100 * n + 1)) begin
                        bad++;
                        $display("FAIL const_avg ch=%0d got=%0d exp=%0d", n, avg_out[0][n], 100 * n + 1);
                    end
                end
            end
            if (e == 50) begin
                total++;
                if (valid_out[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL const_pulse_width got=%b exp=0", valid_out[0]);
                end
            end
        end
        total++;
        if (first_v != 49) begin
            bad++;
            $display("FAIL const_first_valid got=%0d exp=49", first_v);
        end
    endtask

    task automatic test_toggle();
        int last_v;
        int pulses;
        last_v = -1;
        pulses = 0;
        adc_in[0][0] = 16'd0;
        for (int n = 1; n < 8; n++) adc_in[0][n] = 16'(200 + n);
        do_reset();
        for (int e = 1; e <= 130; e++) begin
            @(negedge clk);
            for (int n = 0; n < 8; n++) begin
                total++;
                if (avg_out[0][n] !== m_avg[0][n]) begin
                    bad++;
                    $display("FAIL toggle_model ch=%0d e=%0d got=%0d exp=%0d", n, e, avg_out[0][n], m_avg[0][n]);
                end
            end
            if (valid_out[0] === 1'b1) begin
                pulses++;
                total++;
                if (avg_out[0][0] !== 16'd2047) begin
                    bad++;
                    $display("FAIL toggle_avg0 e=%0d got=%0d exp=2047", e, avg_out[0][0]);
                end
                if (last_v >= 0) begin
                    total++;
                    if (e - last_v != 40) begin
                        bad++;
                        $display("FAIL toggle_period got=%0d exp=40", e - last_v);
                    end
                end
                last_v = e;
            end
            if (e >= 15 && e % 10 == 5)
                adc_in[0][0] = (adc_in[0][0] == 16'd0) ? 16'd4095 : 16'd0;
        end
        total++;
        if (pulses != 3) begin
            bad++;
            $display("FAIL toggle_pulse_count got=%0d exp=3", pulses);
        end
    endtask

    task automatic test_saturate();
        for (int n = 0; n < 8; n++) adc_in[1][n] = 16'hFFFF;
        do_reset();
        for (int e = 1; e <= 172; e++) begin
            @(negedge clk);
            total++;
            if (valid_out[1] !== m_valid[1]) begin
                bad++;
                $display("FAIL sat_valid e=%0d got=%b exp=%b", e, valid_out[1], m_valid[1]);
            end
            if (e == 169) begin
                total++;
                if (valid_out[1] !== 1'b1) begin
                    bad++;
                    $display("FAIL sat_valid_at_169 got=%b exp=1", valid_out[1]);
                end
                for (int n = 0; n < 8; n++) begin
                    total++;
                    if (avg_out[1][n] !== 16'hFFFF) begin
                        bad++;
                        $display("FAIL sat_avg ch=%0d got=%h exp=ffff", n, avg_out[1][n]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 8; n++) adc_in[0][n] = 16'(100 * n + 1);
        do_reset();
        for (int e = 1; e <= 72; e++) begin
            @(negedge clk);
            if (e == 49) begin
                total++;
                if (valid_out[0] !== 1'b1 || avg_out[0][7] !== 16'd701) begin
                    bad++;
                    $display("FAIL rmid_pre got valid=%b avg7=%0d exp valid=1 avg7=701", valid_out[0], avg_out[0][7]);
                end
            end
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (valid_out[0] !== 1'b0) begin
            bad++;
            $display("FAIL rmid_valid got=%b exp=0", valid_out[0]);
        end
        for (int n = 0; n < 8; n++) begin
            total++;
            if (avg_out[0][n] !== 16'h0) begin
                bad++;
                $display("FAIL rmid_avg_cleared ch=%0d got=%0d exp=0", n, avg_out[0][n]);
            end
        end
        rst = 1'b0;
        for (int n = 0; n < 8; n++) adc_in[0][n] = 16'(50 * n + 7);
        for (int e = 1; e <= 55; e++) begin
            @(negedge clk);
            total++;
            if (valid_out[0] !== m_valid[0]) begin
                bad++;
                $display("FAIL rmid_model_valid e=%0d got=%b exp=%b", e, valid_out[0], m_valid[0]);
            end
            if (e == 49) begin
                for (int n = 0; n < 8; n++) begin
                    total++;
                    if (valid_out[0] !== 1'b1 || avg_out[0][n] !== 16'(50 * n + 7)) begin
                        bad++;
                        $display("FAIL rmid_post ch=%0d got valid=%b avg=%0d exp valid=1 avg=%0d",
                                 n, valid_out[0], avg_out[0][n], 50 * n + 7);
                    end
                end
            end
        end
    endtask

    task automatic test_slot_edge();
        for (int n = 0; n < 8; n++) adc_in[0][n] = 16'(n + 1);
        adc_in[0][3] = 16'd10;
        do_reset();
        for (int e = 1; e <= 50; e++) begin
            @(negedge clk);
            if (e == 14) adc_in[0][3] = 16'd1000;
            if (e == 49) begin
                total++;
                if (avg_out[0][3] !== 16'd752) begin
                    bad++;
                    $display("FAIL slot_edge_avg3 got=%0d exp=752", avg_out[0][3]);
                end
                total++;
                if (avg_out[0][3] !== m_avg[0][3]) begin
                    bad++;
                    $display("FAIL slot_edge_model got=%0d exp=%0d", avg_out[0][3], m_avg[0][3]);
                end
            end
        end
    endtask

    task automatic test_sample_hold();
        int last_v;
        last_v = -1;
        do_reset();
        for (int e = 1; e <= 100; e++) begin
            @(negedge clk);
            total++;
            if (valid_out[2] !== m_valid[2]) begin
                bad++;
                $display("FAIL sh_valid e=%0d got=%b exp=%b", e, valid_out[2], m_valid[2]);
            end
            for (int n = 0; n < 8; n++) begin
                total++;
                if (avg_out[2][n] !== m_avg[2][n]) begin
                    bad++;
                    $display("FAIL sh_avg ch=%0d e=%0d got=%0d exp=%0d", n, e, avg_out[2][n], m_avg[2][n]);
                end
            end
            if (valid_out[2] === 1'b1) begin
                if (last_v >= 0) begin
                    total++;
                    if (e - last_v != 12) begin
                        bad++;
                        $display("FAIL sh_period got=%0d exp=12", e - last_v);
                    end
                end
                last_v = e;
            end
            for (int n = 0; n < 8; n++) adc_in[2][n] = 16'($urandom_range(0, 4095));
        end
        total++;
        if (last_v != 93) begin
            bad++;
            $display("FAIL sh_last_pulse got=%0d exp=93", last_v);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int e = 1; e <= 360; e++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                total++;
                if (valid_out[i] !== m_valid[i]) begin
                    bad++;
                    $display("FAIL rand_valid inst=%0d e=%0d got=%b exp=%b", i, e, valid_out[i], m_valid[i]);
                end
                for (int n = 0; n < 8; n++) begin
                    total++;
                    if (avg_out[i][n] !== m_avg[i][n]) begin
                        bad++;
                        $display("FAIL rand_avg inst=%0d ch=%0d e=%0d got=%0d exp=%0d",
                                 i, n, e, avg_out[i][n], m_avg[i][n]);
                    end
                end
            end
            for (int i = 0; i < 3; i++)
                for (int n = 0; n < 8; n++)
                    adc_in[i][n] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 4095));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        for (int i = 0; i < 3; i++)
            for (int n = 0; n < 8; n++)
                adc_in[i][n] = 16'h0;
        test_reset();
        test_constant();
        test_toggle();
        test_saturate();
        test_reset_mid();
        test_slot_edge();
        test_sample_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
